capsense_scanner: RTL and testbench

Parametrised successor of the capsense system controller: periodically scans N capacitive pads using an internal discharge/measure state machine, then debounces each channel.
Per-channel mode mask selects direct or toggle output.
Emits one-cycle press/release event pulses and a scan-complete strobe for downstream logic (LED drivers, CPU IRQ).
Sits between the pad I/O cells and user logic; single clock domain.

---
 rtl/capsense_pkg.sv | 36 +++
 rtl/capsense_debounce.sv | 52 +++++
 rtl/capsense_scanner.sv | 156 +++++++++++++++
 tb/tb_capsense_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/capsense_pkg.sv
// Shared types and sizing helpers for the capacitive pad scanner.
// Defaults mirror the production build (24 MHz clock, 1.5 MHz sample tick).
package capsense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISCH = 2'd1,
    ST_MEAS  = 2'd2,
    ST_EVAL  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to hold every value in 0..v, never less than one.
  function automatic int width_of(input int v);
    return (v < 1) ? 1 : clog2(v + 1);
  endfunction

  function automatic int mod_samp(input int freq_mhz, input int samp_khz);
    return freq_mhz * 1000 / samp_khz;
  endfunction

  localparam int MOD_SAMP   = mod_samp(24, 1500);
  localparam int MOD_SAMP_W = width_of(MOD_SAMP - 1);
  localparam int POLL_CNT_W = width_of(131072 - 1);
  localparam int TICK_CNT_W = width_of(16);
  localparam int DEB_CNT_W  = width_of(2);

endpackage

// File: rtl/capsense_debounce.sv
// One channel: scan-rate debounce, press/release pulses and toggle flop.
// Events and state update the cycle after the upd strobe.
module capsense_debounce
  import capsense_pkg::*;
#(
  parameter int   DEBOUNCE = 2,
  parameter logic TOGGLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic raw,
  output logic deb,
  output logic press,
  output logic rel,
  output logic tog
);

  localparam int CNT_W = width_of(DEBOUNCE);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      deb   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      tog   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (upd) begin
        if (raw != deb) begin
          // The DEBOUNCE-th consecutive disagreeing scan commits the change.
          if (cnt == CNT_W'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            deb   <= raw;
            press <= raw;
            rel   <= ~raw;
            if (TOGGLE && raw) tog <= ~tog;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/capsense_scanner.sv
// Periodic discharge/measure scanner for N capacitive pads with per-channel debounce.
// Events and scan_done_o appear the cycle after EVAL; overrun_o flags a poll arriving mid-scan.
module capsense_scanner
  import capsense_pkg::*;
#(
  parameter int             N           = 4,
  parameter int             FREQUENCY   = 24,
  parameter int             SAMP_KHZ    = 1500,
  parameter int             POLL_TICKS  = 131072,
  parameter int             DISCH_TICKS = 16,
  parameter int             THRESH      = 12,
  parameter int             DEBOUNCE    = 2,
  parameter logic [N-1:0]   TOGGLE_MASK = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] capsense_i,
  output logic         capsense_oe,
  output logic [N-1:0] buttons_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic         scan_done_o,
  output logic         overrun_o,
  output logic [N-1:0] debug_o
);

  localparam int DIV_MOD = mod_samp(FREQUENCY, SAMP_KHZ);
  localparam int DIV_W   = width_of(DIV_MOD - 1);
  localparam int POLL_W  = width_of(POLL_TICKS - 1);
  localparam int M_W     = width_of((DISCH_TICKS > THRESH) ? DISCH_TICKS : THRESH);

  logic [N-1:0]      sync1, sync2;
  logic [DIV_W-1:0]  div_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [M_W-1:0]    m;
  logic [N-1:0]      risen;
  logic [N-1:0]      deb, tog;
  logic              tick, poll_start, upd;
  state_t            state, state_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= capsense_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(DIV_MOD - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == '0) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= (poll_cnt == POLL_W'(POLL_TICKS - 1)) ? '0 : poll_cnt + POLL_W'(1);
    end
  end

  assign poll_start = tick && (poll_cnt == '0);
  assign upd        = (state == ST_EVAL);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capsense_oe = 1'b0;
    debug_o     = '0;
    case (state)
      ST_IDLE: begin
        if (poll_start) state_next = ST_DISCH;
      end
      ST_DISCH: begin
        capsense_oe = 1'b1;
        if (tick && m == M_W'(DISCH_TICKS - 1)) state_next = ST_MEAS;
      end
      ST_MEAS: begin
        debug_o = ~risen;
        if ((&risen) || (tick && m == M_W'(THRESH - 1))) state_next = ST_EVAL;
      end
      ST_EVAL: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // m counts sample ticks within DISCH and MEAS; risen latches pads seen high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m     <= '0;
      risen <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (poll_start) begin
            m     <= '0;
            risen <= '0;
          end
        end
        ST_DISCH: begin
          if (tick) m <= (m == M_W'(DISCH_TICKS - 1)) ? '0 : m + M_W'(1);
        end
        ST_MEAS: begin
          if (tick && !(&risen)) begin
            risen <= risen | sync2;
            m     <= m + M_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_done_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      scan_done_o <= upd;
      if (poll_start && state != ST_IDLE) overrun_o <= 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    capsense_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .TOGGLE   (TOGGLE_MASK[i])
    ) u_deb (
      .clk   (clk_i),
      .rst   (rst_i),
      .upd   (upd),
      .raw   (~risen[i]),
      .deb   (deb[i]),
      .press (press_o[i]),
      .rel   (release_o[i]),
      .tog   (tog[i])
    );
    assign buttons_o[i] = TOGGLE_MASK[i] ? tog[i] : deb[i];
  end

endmodule

// File: tb/tb_capsense_scanner.sv
// Directed bench: reset/discharge timing, table of per-scan debounce vectors,
// reset mid-measure and overrun on a second instance with a short poll period.
module tb_capsense_scanner;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [3:0] pads, pads2;

  logic       oe, done, ovr;
  logic [3:0] btn, prs, rls, dbg;
  logic       oe2, done2, ovr2;
  logic [3:0] btn2, prs2, rls2, dbg2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  capsense_scanner #(
    .N(4), .FREQUENCY(4), .SAMP_KHZ(1000), .POLL_TICKS(64), .DISCH_TICKS(4),
    .THRESH(8), .DEBOUNCE(2), .TOGGLE_MASK(4'b0010)
  ) dut (
    .clk_i(clk), .rst_i(rst), .capsense_i(pads), .capsense_oe(oe),
    .buttons_o(btn), .press_o(prs), .release_o(rls), .scan_done_o(done),
    .overrun_o(ovr), .debug_o(dbg)
  );

  capsense_scanner #(
    .N(4), .FREQUENCY(4), .SAMP_KHZ(1000), .POLL_TICKS(8), .DISCH_TICKS(4),
    .THRESH(8), .DEBOUNCE(2), .TOGGLE_MASK(4'b0010)
  ) dut2 (
    .clk_i(clk), .rst_i(rst2), .capsense_i(pads2), .capsense_oe(oe2),
    .buttons_o(btn2), .press_o(prs2), .release_o(rls2), .scan_done_o(done2),
    .overrun_o(ovr2), .debug_o(dbg2)
  );

  // cyc = k+1 in the interval following the k-th edge after reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int off, output bit ok);
    ok  = 1'b0;
    off = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok  = 1'b1;
        off = (cyc - 1) % 256;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] pads;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] btn;
    int         off;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int off;
    bit ok;

    // pad bit 0 = never rises (touched); off = scan_done interval within the 256-cycle poll
    tbl[0]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000, 49};
    tbl[1]  = '{4'b1110, 4'b0001, 4'b0000, 4'b0001, 49};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 22};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 22};
    tbl[4]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 49};
    tbl[5]  = '{4'b1101, 4'b0010, 4'b0000, 4'b0010, 49};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 22};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0010, 22};
    tbl[8]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0010, 49};
    tbl[9]  = '{4'b1101, 4'b0010, 4'b0000, 4'b0000, 49};
    tbl[10] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 22};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0010, 4'b0000, 22};
    tbl[12] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 49};
    tbl[13] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 22};
    tbl[14] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 49};
    tbl[15] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 49};
    tbl[16] = '{4'b0000, 4'b1011, 4'b0000, 4'b1111, 49};

    rst = 1'b1; rst2 = 1'b1; pads = 4'b0000; pads2 = 4'b0000;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {oe, btn, prs, rls, done, ovr, dbg}, '0);
      chk("reset_outputs2", {oe2, btn2, prs2, rls2, done2, ovr2, dbg2}, '0);
    end
    rst = 1'b0;

    // Discharge: oe high for intervals 0..15 (16 clocks), MEAS from 16.
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("oe_interval_%0d", k), oe, (k < 16) ? 1 : 0);
    end
    chk("debug_meas_entry", dbg, 4'b1111);

    // All pads rise two ticks into MEAS: early exit, scan_done at interval 30.
    repeat (8) @(negedge clk);
    pads = 4'b1111;
    wait_done(off, ok);
    chk("scan0_done_seen", ok, 1);
    chk("scan0_offset", off, 30);
    chk("scan0_press", prs, 0);
    chk("scan0_release", rls, 0);
    chk("scan0_buttons", btn, 0);
    @(negedge clk);
    chk("scan0_done_pulse_width", done, 0);

    for (int i = 0; i < 17; i++) begin
      pads = tbl[i].pads;
      wait_done(off, ok);
      chk($sformatf("row%0d_done_seen", i), ok, 1);
      chk($sformatf("row%0d_offset", i), off, tbl[i].off);
      chk($sformatf("row%0d_press", i), prs, tbl[i].press);
      chk($sformatf("row%0d_release", i), rls, tbl[i].rel);
      chk($sformatf("row%0d_buttons", i), btn, tbl[i].btn);
      @(negedge clk);
      chk($sformatf("row%0d_pulses_end", i), {done, prs, rls}, 0);
      chk($sformatf("row%0d_buttons_hold", i), btn, tbl[i].btn);
      chk($sformatf("row%0d_no_overrun", i), ovr, 0);
    end

    // Reset while measuring with channels debounced high.
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (dbg != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    chk("meas_reached_before_reset", ok, 1);
    chk("buttons_before_reset", btn, 4'b1111);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midscan_reset_outputs", {oe, btn, prs, rls, done, ovr, dbg}, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rescan_oe", oe, 1);

    // Short poll period: the poll at interval 32 lands in MEAS.
    rst2 = 1'b0;
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      if (k == 31) chk("overrun_before", ovr2, 0);
      if (k == 32) chk("overrun_set", ovr2, 1);
      if (k == 200) chk("overrun_sticky", ovr2, 1);
    end
    rst2 = 1'b1;
    @(negedge clk);
    chk("overrun_cleared_by_reset", ovr2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
